// File: rtl/pb_rect_blitter.sv
// pb_rect_blitter: rectangle fill/outline/clear engine driving the pixel buffer write port, one pixel per clock.
module pb_rect_blitter #(
  parameter int ADDR_W  = 15,
  parameter int DATA_W  = 4,
  parameter int FB_W    = 160,
  parameter int FB_H    = 120,
  parameter int COORD_W = 8
) (
  input  logic               clk_clk,
  input  logic               reset_reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [COORD_W-1:0] cmd_x,
  input  logic [COORD_W-1:0] cmd_y,
  input  logic [COORD_W-1:0] cmd_w,
  input  logic [COORD_W-1:0] cmd_h,
  input  logic [DATA_W-1:0]  cmd_colour,
  input  logic [1:0]         cmd_mode,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [ADDR_W-1:0]  pb_adr_export,
  output logic [DATA_W-1:0]  pb_data_export,
  output logic               pbuff_wren_export
);
  localparam int C_W  = COORD_W + 1;
  localparam int P_W  = C_W + $clog2(FB_W + 1);
  localparam int RB_W = (P_W > ADDR_W) ? P_W : ADDR_W;
  localparam logic [C_W-1:0]  FBW_C = C_W'(FB_W);
  localparam logic [C_W-1:0]  FBH_C = C_W'(FB_H);
  localparam logic [RB_W-1:0] FBW_R = RB_W'(FB_W);
  typedef enum logic [1:0] {IDLE, SETUP, RUN, DONE} state_t;
  state_t r_state, w_state_n;
  logic [COORD_W-1:0] r_cx, r_cy, r_cw, r_ch;
  logic [DATA_W-1:0]  r_colour, r_data;
  logic [1:0]         r_mode;
  logic [C_W-1:0]     r_x0, r_y0, r_xe, r_ye, r_x, r_y;
  logic [RB_W-1:0]    r_rb;
  logic [ADDR_W-1:0]  r_adr;
  logic               r_err, r_wren;
  logic               w_clear, w_skip, w_edge_row, w_row_end, w_last, w_load;
  logic [C_W-1:0]     w_sx0, w_sy0, w_sw, w_sh, w_nx, w_ny, w_px, w_py;
  logic [RB_W-1:0]    w_nrb, w_prb, w_pix_adr;
  always_comb begin
    w_clear    = r_mode == 2'd2;
    w_sx0      = w_clear ? '0 : C_W'(r_cx);
    w_sy0      = w_clear ? '0 : C_W'(r_cy);
    w_sw       = w_clear ? FBW_C : C_W'(r_cw);
    w_sh       = w_clear ? FBH_C : C_W'(r_ch);
    w_skip     = r_mode == 2'd3 || w_sw == '0 || w_sh == '0;
    w_edge_row = r_y == r_y0 || r_y == r_ye;
    w_row_end  = r_x == r_xe;
    w_last     = w_row_end && r_y == r_ye;
    // Outline interior rows jump straight from the left edge to the right edge.
    w_nx       = w_row_end ? r_x0 : (r_mode == 2'd1 && !w_edge_row) ? r_xe : r_x + 1'b1;
    w_ny       = w_row_end ? r_y + 1'b1 : r_y;
    w_nrb      = w_row_end ? r_rb + FBW_R : r_rb;
    w_px       = r_state == SETUP ? w_sx0 : w_nx;
    w_py       = r_state == SETUP ? w_sy0 : w_ny;
    w_prb      = r_state == SETUP ? RB_W'(w_sy0) * FBW_R : w_nrb;
    w_load     = (r_state == SETUP && !w_skip) || (r_state == RUN && !w_last);
    w_pix_adr  = w_prb + RB_W'(w_px);
    w_state_n  = r_state == IDLE  ? (cmd_valid ? SETUP : IDLE) :
                 r_state == SETUP ? (w_skip ? DONE : RUN) :
                 r_state == RUN   ? (w_last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_state  <= IDLE;
      r_cx     <= '0;
      r_cy     <= '0;
      r_cw     <= '0;
      r_ch     <= '0;
      r_colour <= '0;
      r_mode   <= '0;
      r_x0     <= '0;
      r_y0     <= '0;
      r_xe     <= '0;
      r_ye     <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_rb     <= '0;
      r_err    <= 1'b0;
      r_adr    <= '0;
      r_data   <= '0;
      r_wren   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      if (r_state == IDLE && cmd_valid) begin
        r_cx     <= cmd_x;
        r_cy     <= cmd_y;
        r_cw     <= cmd_w;
        r_ch     <= cmd_h;
        r_colour <= cmd_colour;
        r_mode   <= cmd_mode;
      end
      if (r_state == SETUP) begin
        r_x0  <= w_sx0;
        r_y0  <= w_sy0;
        r_xe  <= w_sx0 + w_sw - 1'b1;
        r_ye  <= w_sy0 + w_sh - 1'b1;
        r_err <= r_mode == 2'd3;
      end
      if (r_state == SETUP || r_state == RUN) begin
        r_x  <= w_px;
        r_y  <= w_py;
        r_rb <= w_prb;
      end
      r_wren <= w_load && w_px < FBW_C && w_py < FBH_C;
      if (w_load) begin
        r_adr  <= w_pix_adr[ADDR_W-1:0];
        r_data <= r_colour;
      end
    end
  end
  assign cmd_ready         = r_state == IDLE;
  assign busy              = r_state != IDLE;
  assign done              = r_state == DONE;
  assign err               = r_state == DONE && r_err;
  assign pb_adr_export     = r_adr;
  assign pb_data_export    = r_data;
  assign pbuff_wren_export = r_wren;
endmodule
